// File: rtl/shift_pkg.sv
// Shared types and defaults for the multi-cycle shift sequencer.
// Holds the FSM state encoding and the legality rule for the per-cycle step size.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AMT_W = 4;
    localparam int DEF_STEP  = 1;
    localparam int STEP_MAX  = 8;

    // STEP must be a power of two in 1..STEP_MAX.
    function automatic bit step_legal(input int s);
        return (s >= 1) && (s <= STEP_MAX) && ((s & (s - 1)) == 0);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by n (0..STEP) bits in one cycle.
// Supports left, logical right, arithmetic right and rotate in either direction.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP,
    parameter int NW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [NW-1:0]    n_i,
    input  logic             left_i,
    input  logic             arith_i,
    input  logic             rot_i,
    output logic [WIDTH-1:0] value_o
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rot_l;
    logic [2*WIDTH-1:0] rot_r;

    // Rotation is a shift of the value concatenated with itself.
    assign dbl   = {value_i, value_i};
    assign rot_l = dbl << n_i;
    assign rot_r = dbl >> n_i;

    always_comb begin
        value_o = value_i;
        if (rot_i) begin
            if (left_i) begin
                value_o = rot_l[2*WIDTH-1:WIDTH];
            end else begin
                value_o = rot_r[WIDTH-1:0];
            end
        end else if (left_i) begin
            value_o = value_i << n_i;
        end else if (arith_i) begin
            value_o = $unsigned($signed(value_i) >>> n_i);
        end else begin
            value_o = value_i >> n_i;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts one op, iterates shift_step STEP bits per cycle, holds result.
// Optional rotate support is compiled in when SHIFT_ROTATE_EN is defined.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W,
    parameter int STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_left,
    input  logic             in_arith,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int NW = $clog2(STEP + 1);

    if (!step_legal(STEP)) begin : g_bad_step
        $error("shift_sequencer: STEP must be a power of two in 1..8");
    end

    state_t           state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;
    logic             rot_eff;
    logic             accept;
    logic [NW-1:0]    step_n;
    logic [WIDTH-1:0] step_out;

    assign accept = in_valid && in_ready_q;

`ifdef SHIFT_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rot_q <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            rot_q <= in_rot;
        end
    end

    assign rot_eff = rot_q;
`else
    logic unused_rot;

    assign unused_rot = in_rot;
    assign rot_eff    = 1'b0;
`endif

    // Last step of an op may be shorter than STEP.
    assign step_n = (int'(rem_q) < STEP) ? NW'(rem_q) : NW'(STEP);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .NW    (NW)
    ) u_step (
        .value_i (data_q),
        .n_i     (step_n),
        .left_i  (left_q),
        .arith_i (arith_q),
        .rot_i   (rot_eff),
        .value_o (step_out)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rem_d      = rem_q;
        left_d     = left_q;
        arith_d    = arith_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    rem_d   = in_amt;
                    left_d  = in_left;
                    arith_d = in_arith;
                    if (in_amt == '0) begin
                        state_d    = DONE;
                        out_data_d = in_data;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d = step_out;
                rem_d  = rem_q - AMT_W'(step_n);
                if (rem_d == '0) begin
                    state_d    = DONE;
                    out_data_d = step_out;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            data_q      <= '0;
            rem_q       <= '0;
            left_q      <= 1'b0;
            arith_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            out_data_q  <= out_data_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            left_q      <= left_d;
            arith_q     <= arith_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);

endmodule
